seq_div_32by16: RTL

Sequential restoring divider producing the inverse of the 16x16 Dadda multiplier: divides a 2N-bit dividend (the multiplier's product width) by an N-bit divisor, yielding N-bit quotient and remainder. It retires one quotient bit per cycle behind a valid/ready handshake on both sides. It sits next to the Dadda multiplier in the arithmetic datapath and closes the loop for multiply/divide round-trip checking.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 27 ++
 rtl/seq_div_32by16.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 32/16 restoring divider.
package div_pkg;

  localparam int unsigned DIV_N     = 16;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts {rem,qreg} left and retires one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] qreg_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] qreg_o
);

  logic [N:0]   rem_sh;
  logic [N+1:0] trial;
  logic         fits;

  // A set rem MSB means the shifted value is >= 2^(N+1) and always exceeds B.
  always_comb begin
    rem_sh = {rem_i[N-1:0], qreg_i[N-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_i};
    fits   = rem_i[N] | ~trial[N+1];
    rem_o  = fits ? trial[N:0] : rem_sh;
    qreg_o = {qreg_i[N-2:0], fits};
  end

endmodule

// File: rtl/seq_div_32by16.sv
// Sequential 2N/N unsigned restoring divider with valid/ready handshakes.
// Optional DIV_ERR_EN macro enables divide-by-zero / quotient-overflow early exit.
module seq_div_32by16
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*DIV_N-1:0]   A,
  input  logic [DIV_N-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIV_N-1:0]     Q,
  output logic [DIV_N-1:0]     R,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int unsigned N = DIV_N;

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]           rem_q, rem_d;
  logic [N-1:0]         qreg_q, qreg_d;
  logic [N-1:0]         b_q, b_d;
  logic [N-1:0]         q_q, q_d;
  logic [N-1:0]         r_q, r_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [N:0]           step_rem;
  logic [N-1:0]         step_qreg;

`ifdef DIV_ERR_EN
  logic                 div_zero_q, div_zero_d;
  logic                 ovf_q, ovf_d;
`endif

  div_step #(.N(N)) u_step (
    .rem_i  (rem_q),
    .qreg_i (qreg_q),
    .b_i    (b_q),
    .rem_o  (step_rem),
    .qreg_o (step_qreg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qreg_q      <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DIV_ERR_EN
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      qreg_q      <= qreg_d;
      b_q         <= b_d;
      q_q         <= q_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef DIV_ERR_EN
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    qreg_d      = qreg_q;
    b_d         = b_q;
    q_d         = q_q;
    r_d         = r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef DIV_ERR_EN
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          b_d        = B;
          rem_d      = {1'b0, A[2*N-1:N]};
          qreg_d     = A[N-1:0];
          cnt_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
`ifdef DIV_ERR_EN
          div_zero_d = (B == '0);
          ovf_d      = (B != '0) && (A[2*N-1:N] >= B);
          // Either error bypasses CALC with a saturated quotient.
          if ((B == '0) || (A[2*N-1:N] >= B)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            q_d         = '1;
            r_d         = A[N-1:0];
          end
`endif
        end
      end

      CALC: begin
        rem_d  = step_rem;
        qreg_d = step_qreg;
        cnt_d  = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          q_d         = step_qreg;
          r_d         = step_rem[N-1:0];
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign R         = r_q;

`ifdef DIV_ERR_EN
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;
`else
  assign div_zero = 1'b0;
  assign ovf      = 1'b0;
`endif

endmodule
